// File: rtl/ifc_defs_pkg.sv
// rtl/ifc_defs_pkg.sv - shared state encoding, NOP word and alignment helper for the fetch controller
package ifc_defs;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  localparam logic [31:0] NOP = 32'h0000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register; flush beats hold, hold beats load
module if_id_reg
  import ifc_defs::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        hold,
  input  logic        flush,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc4,
  output logic [31:0] instr,
  output logic [31:0] pc4,
  output logic        valid
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;

  always_comb begin
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (flush) begin
      instr_d = NOP;
      pc4_d   = 32'h0;
      valid_d = 1'b0;
    end else if (!hold) begin
      instr_d = in_instr;
      pc4_d   = in_pc4;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q <= NOP;
      pc4_q   <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign instr = instr_q;
  assign pc4   = pc4_q;
  assign valid = valid_q;

endmodule

// File: rtl/instr_fetch_ctrl.sv
// rtl/instr_fetch_ctrl.sv - fetch-stage controller: PC, redirects, IF/ID and shared loader/fetch memory port
module instr_fetch_ctrl
  import ifc_defs::*;
#(
  parameter int          DEPTH    = 128,
  parameter int          AW       = $clog2(DEPTH),
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_valid,
  output logic          load_ready,
  input  logic [AW-1:0] load_addr,
  input  logic [31:0]   load_data,
  input  logic          start,
  input  logic          halt_req,
  input  logic          stall,
  input  logic          branch_taken,
  input  logic [31:0]   branch_target,
  input  logic          jump,
  input  logic [31:0]   jump_target,
  output logic [31:0]   imem_addr,
  output logic          imem_we,
  output logic [31:0]   imem_wdata,
  input  logic [31:0]   imem_rdata,
  output logic [31:0]   if_id_instr,
  output logic [31:0]   if_id_pc4,
  output logic          if_id_valid,
  output logic          halted,
  output logic          fetch_err,
  output logic [31:0]   fetch_cnt
);

  localparam logic [31:0] PC_LIMIT = 32'(DEPTH * 4);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        fetch_err_q, fetch_err_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;

  logic        redirect;
  logic [31:0] redir_raw;
  logic [31:0] redir_pc;
  logic        redir_misaligned;
  logic [31:0] pc_plus4;
  logic        ifid_hold;
  logic        ifid_flush;

  // Branch outranks jump when both resolve in the same cycle.
  always_comb begin
    redirect         = branch_taken | jump;
    redir_raw        = branch_taken ? branch_target : jump_target;
    redir_pc         = word_align(redir_raw);
    redir_misaligned = (redir_raw[1:0] != 2'b00);
    pc_plus4         = pc_q + 32'd4;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_PC;
      fetch_err_q <= 1'b0;
      fetch_cnt_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      fetch_err_q <= fetch_err_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    fetch_err_d = fetch_err_q;
    fetch_cnt_d = fetch_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !load_valid) begin
          state_d = ST_RUN;
          pc_d    = RESET_PC;
        end
      end
      ST_RUN: begin
        if (halt_req) begin
          state_d = ST_HALT;
        end else if (redirect) begin
          pc_d = redir_pc;
          if (redir_misaligned) fetch_err_d = 1'b1;
          if (redir_pc >= PC_LIMIT) state_d = ST_HALT;
        end else if (!stall) begin
          // The last word is still latched; only then do we stop, without wrapping pc.
          pc_d        = pc_plus4;
          fetch_cnt_d = fetch_cnt_q + 32'd1;
          if (pc_plus4 >= PC_LIMIT) state_d = ST_HALT;
        end
      end
      ST_HALT: begin
        if (load_valid) begin
          state_d = ST_IDLE;
        end else if (start) begin
          state_d = ST_RUN;
          pc_d    = RESET_PC;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    load_ready = (state_q != ST_RUN);
    imem_we    = load_ready & load_valid;
    imem_wdata = load_data;
    imem_addr  = {{(32 - AW - 2){1'b0}}, load_addr, 2'b00};
    if (state_q == ST_RUN) imem_addr = pc_q;
    halted     = (state_q == ST_HALT);
    ifid_flush = (state_q != ST_RUN) | halt_req | redirect;
    ifid_hold  = stall;
  end

  if_id_reg u_if_id_reg (
    .clk      (clk),
    .rst      (reset),
    .hold     (ifid_hold),
    .flush    (ifid_flush),
    .in_instr (imem_rdata),
    .in_pc4   (pc_plus4),
    .instr    (if_id_instr),
    .pc4      (if_id_pc4),
    .valid    (if_id_valid)
  );

  assign fetch_err = fetch_err_q;
  assign fetch_cnt = fetch_cnt_q;

endmodule
